// File: rtl/audioport_pkg.sv
// Shared audioport constants and types for the I2S transmit path.
package audioport_pkg;
    localparam int I2S_WORD_W      = 24;
    localparam int I2S_FRAME_SLOTS = 48;

    typedef enum logic [1:0] {IDLE, RUN, STOP} i2s_state_t;
    typedef logic [1:0][I2S_WORD_W-1:0] audio_sample_t;
endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: serialises stereo 24-bit samples onto sck/ws/sdo with the standard
// one-sck data delay, fed through a one-entry holding register.
module i2s_tx
    import audioport_pkg::*;
#(
    parameter int SCK_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_in,
    input  logic [47:0] audio_in,
    input  logic        audio_in_valid,
    output logic        audio_in_ready,
    output logic        sck,
    output logic        ws,
    output logic        sdo,
    output logic        underflow_out
);
    localparam int            PERIOD    = 2 * SCK_HALF;
    localparam int            PW        = $clog2(PERIOD);
    localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_RISE   = PW'(SCK_HALF);
    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [5:0]    SLOT_LAST = 6'(I2S_FRAME_SLOTS - 1);
    localparam logic [5:0]    SLOT_WS   = 6'(I2S_WORD_W);

    i2s_state_t    state;
    logic [PW-1:0] phase, phase_nxt;
    logic [5:0]    slot, slot_nxt;
    logic [47:0]   shreg;
    logic          lsb;
    audio_sample_t hold, src;
    logic          full, drain;
    logic          slot_end, load, to_idle;

    always_comb begin
        slot_end  = (state != IDLE) && (phase == PH_LAST);
        phase_nxt = slot_end ? '0 : phase + PH_ONE;
        slot_nxt  = (slot == SLOT_LAST) ? '0 : slot + 6'd1;
        // drain is set only when slot 0 was entered while stopping, so the frame in flight completes
        to_idle   = slot_end && (slot == 6'd0) && (state == STOP) && drain && !play_in;
        load      = slot_end && (slot_nxt == 6'd1) && !to_idle;
        src       = full ? hold : '0;
    end

    assign audio_in_ready = !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= '0;
            slot          <= '0;
            shreg         <= '0;
            lsb           <= 1'b0;
            hold          <= '0;
            full          <= 1'b0;
            drain         <= 1'b0;
            sck           <= 1'b0;
            ws            <= 1'b0;
            sdo           <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            underflow_out <= 1'b0;

            // A write coinciding with a load lands after it; the load still sees the old contents.
            if (audio_in_valid && !full) begin
                hold <= audio_in;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end

            if (state == IDLE || to_idle) begin
                state <= (state == IDLE && play_in) ? RUN : IDLE;
                phase <= '0;
                slot  <= '0;
                shreg <= '0;
                lsb   <= 1'b0;
                drain <= 1'b0;
                sck   <= 1'b0;
                ws    <= 1'b0;
                sdo   <= 1'b0;
            end else begin
                state <= play_in ? RUN : STOP;
                phase <= phase_nxt;
                sck   <= (phase_nxt >= PH_RISE);
                if (play_in)
                    drain <= 1'b0;
                if (slot_end) begin
                    slot <= slot_nxt;
                    ws   <= (slot_nxt >= SLOT_WS);
                    if (slot_nxt == 6'd0) begin
                        sdo   <= lsb;
                        drain <= !play_in;
                    end else if (slot_nxt == 6'd1) begin
                        sdo           <= src[1][I2S_WORD_W-1];
                        shreg         <= {src[1][I2S_WORD_W-2:0], src[0], 1'b0};
                        lsb           <= src[0][0];
                        underflow_out <= !full;
                    end else begin
                        sdo   <= shreg[47];
                        shreg <= {shreg[46:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: time-based behavioural model, bit-level I2S monitor
// and a set of hand-computed expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_i2s_tx;
    localparam int H  = 4;
    localparam int P2 = 2 * H;
    localparam int F  = 48 * P2;

    logic        clk = 1'b0, rst = 1'b1, play_in = 1'b0, audio_in_valid = 1'b0;
    logic [47:0] audio_in = '0;
    logic        audio_in_ready, sck, ws, sdo, underflow_out;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    i2s_tx #(.SCK_HALF(H)) dut (
        .clk(clk), .rst(rst), .play_in(play_in), .audio_in(audio_in),
        .audio_in_valid(audio_in_valid), .audio_in_ready(audio_in_ready),
        .sck(sck), .ws(ws), .sdo(sdo), .underflow_out(underflow_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: t counts clks since RUN entry; every output follows from t and the current sample.
    bit          m_act = 1'b0, m_full = 1'b0, m_uf = 1'b0;
    int          m_t = 0, m_low = -1;
    logic [47:0] m_cur = '0, m_hold = '0;
    logic [47:0] exp_q[$];

    always @(posedge clk) begin : model
        bit act, full, uf;
        int t, low;
        logic [47:0] cur, hold;
        act = m_act; full = m_full; t = m_t; low = m_low; cur = m_cur; hold = m_hold; uf = 1'b0;
        if (rst) begin
            act = 1'b0; full = 1'b0; t = 0; low = -1; cur = '0;
            exp_q.delete();
        end else begin
            if (!act) begin
                if (play_in) begin act = 1'b1; t = 0; cur = '0; low = -1; end
            end else begin
                t++;
                if (play_in) low = -1;
                else if (low < 0) low = t;
                if (t % F == P2) begin
                    if (!play_in && low >= 0 && low <= t - P2) begin
                        act = 1'b0; t = 0;
                    end else begin
                        cur = m_full ? m_hold : '0;
                        uf = !m_full;
                        full = 1'b0;
                        exp_q.push_back(cur);
                    end
                end
            end
            if (audio_in_valid && !m_full) begin hold = audio_in; full = 1'b1; end
        end
        m_act <= act; m_full <= full; m_uf <= uf; m_t <= t; m_low <= low;
        m_cur <= cur; m_hold <= hold;
    end

    // Per-cycle compare plus a receiver that samples on sck rise and frames on ws falling.
    logic [47:0] hist = '0, mon_last = '0;
    int  mon_n = 0, uf_cnt = 0, sck_t = 0, sck_per = 0, ws_t = 0, ws_per = 0;
    bit  sck_q = 1'b0, ws_q = 1'b0, last_ws = 1'b0;

    always @(negedge clk) begin : compare
        logic [4:0] e;
        int s;
        s = (m_t / P2) % 48;
        e = {!m_full, m_uf, m_act && ((m_t % P2) >= H), m_act && (s >= 24),
             m_act && m_cur[(48 - s) % 48]};
        if (chk_en)
            chk("cycle", 48'({audio_in_ready, underflow_out, sck, ws, sdo}), 48'(e));
        if (underflow_out) uf_cnt++;
        if (rst) begin
            hist = '0; last_ws = 1'b0;
        end else if (sck && !sck_q) begin
            hist = {hist[46:0], sdo};
            if (!ws && last_ws) begin
                mon_last = hist;
                mon_n++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_extra: got %h expected no frame", hist);
                end else begin
                    chk("mon_pair", hist, exp_q.pop_front());
                end
            end
            last_ws = ws;
            sck_per = cyc - sck_t; sck_t = cyc;
        end
        if (ws && !ws_q) begin ws_per = cyc - ws_t; ws_t = cyc; end
        sck_q = sck; ws_q = ws;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [47:0] d);
        audio_in = d; audio_in_valid = 1'b1;
        tick(1);
        audio_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; play_in = 1'b0; audio_in_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, n0, u0;
        // Reset and long IDLE
        tick(2);
        chk_en = 1'b1;
        chk("reset_out", 48'({audio_in_ready, underflow_out, sck, ws, sdo}), 48'h10);
        rst = 1'b0;
        tick(1000);
        chk("idle_out", 48'({audio_in_ready, underflow_out, sck, ws, sdo}), 48'h10);
        chk("idle_uf", 48'(uf_cnt), 48'd0);

        // Single frame written in IDLE
        n0 = mon_n;
        write(48'hA5A5A5_3C3C3C);
        chk("ready_after_write", 48'(audio_in_ready), 48'd0);
        play_in = 1'b1;
        n = 0;
        do begin tick(1); n++; end while (!audio_in_ready && n < 50);
        chk("ready_rise", 48'(n - 1), 48'd8);
        play_in = 1'b0;
        tick(800);
        chk("single_pair", mon_last, 48'hA5A5A5_3C3C3C);
        chk("single_count", 48'(mon_n - n0), 48'd1);

        // Streaming random samples
        do_reset();
        n0 = mon_n; u0 = uf_cnt;
        write({16'($urandom), $urandom});
        play_in = 1'b1;
        repeat (20 * F) begin
            tick(1);
            audio_in_valid = audio_in_ready;
            if (audio_in_ready) audio_in = {16'($urandom), $urandom};
        end
        audio_in_valid = 1'b0;
        chk("stream_uf", 48'(uf_cnt - u0), 48'd0);
        chk("stream_pairs", 48'(mon_n - n0), 48'd19);
        chk("ws_period", 48'(ws_per), 48'(F));
        chk("sck_period", 48'(sck_per), 48'(P2));
        play_in = 1'b0;
        tick(800);

        // Underflow: run without writes
        do_reset();
        u0 = uf_cnt;
        play_in = 1'b1;
        tick(3 * F);
        play_in = 1'b0;
        tick(800);
        chk("underflow_cnt", 48'(uf_cnt - u0), 48'd3);
        chk("underflow_pair", mon_last, 48'h0);

        // Stop at slot 10: frame completes, right LSB goes out in the drain slot
        do_reset();
        write(48'hFFFFFF_000001);
        play_in = 1'b1;
        tick(82);
        play_in = 1'b0;
        tick(303);
        chk("drain_sdo", 48'(sdo), 48'd1);
        chk("drain_ws", 48'(ws), 48'd0);
        tick(8);
        chk("drain_idle", 48'({underflow_out, sck, ws, sdo}), 48'h0);
        chk("stop_pair", mon_last, 48'hFFFFFF_000001);

        // Resume during the drain slot continues without a gap
        tick(10);
        n0 = mon_n;
        write(48'h123456_654321);
        play_in = 1'b1;
        tick(82);
        play_in = 1'b0;
        tick(118);
        write(48'h0F0F0F_F0F0F0);
        tick(186);
        play_in = 1'b1;
        u0 = uf_cnt;
        tick(300);
        play_in = 1'b0;
        tick(800);
        chk("resume_uf", 48'(uf_cnt - u0), 48'd0);
        chk("resume_pair", mon_last, 48'h0F0F0F_F0F0F0);
        chk("resume_count", 48'(mon_n - n0), 48'd2);

        // Reset at slot 30 with the holding register full
        do_reset();
        write(48'h111111_222222);
        play_in = 1'b1;
        tick(40);
        write(48'h333333_444444);
        chk("midrst_full", 48'(audio_in_ready), 48'd0);
        tick(202);
        rst = 1'b1; play_in = 1'b0;
        tick(1);
        chk("midrst_out", 48'({audio_in_ready, underflow_out, sck, ws, sdo}), 48'h10);
        rst = 1'b0;
        tick(20);
        chk("midrst_idle", 48'({audio_in_ready, underflow_out, sck, ws, sdo}), 48'h10);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S transmitter that serialises stereo 24-bit audio samples into the sck/ws/sdo bus of the audioport. It sits between the audio datapath and the `i2s_if` bus and drives that interface's three signals. Each stereo sample (left in bits 47:24, right in bits 23:0) is accepted through a one-entry holding register with a valid/ready handshake. Play/stop is controlled by `play_in`; stopping always completes the current frame.

## Interface
- `SCK_HALF`, default 4: clk cycles per sck half-period; sck period = 2*SCK_HALF clk, must be ≥ 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `play_in` input 1: 1 = transmit, 0 = stop at next frame end.
- `audio_in` input 48: stereo sample, [47:24] left, [23:0] right.
- `audio_in_valid` input 1: `audio_in` is valid.
- `audio_in_ready` output 1: holding register is empty.
- `sck` output 1: I2S serial clock.
- `ws` output 1: word select; 0 = left, 1 = right.
- `sdo` output 1: serial data, MSB first.
- `underflow_out` output 1: one-clk pulse when a frame starts with an empty holding register.

## Operation
- **Reset values:** `sck`=0, `ws`=0, `sdo`=0, `underflow_out`=0, `audio_in_ready`=1. State is IDLE, the holding register is empty, and all counters are 0.
- **Handshake:**
  - A write occurs when `audio_in_valid` && `audio_in_ready`.
  - The holding register is written in any state, including IDLE.
  - `audio_in_ready` = holding register empty.
- **States:**
  - IDLE: all outputs are 0 and counters are held at 0. When `play_in` = 1, go to RUN.
  - RUN: transmit frames. When `play_in` = 0, go to STOP.
  - STOP: continue transmitting. If `play_in` = 1, return to RUN with no discontinuity. After the end of slot 0 of the following frame, go to IDLE.
- **Slots:** a frame is 48 slots, numbered 0..47. One slot = one sck period.
  - `ws` = 0 in slots 0..23 and 1 in slots 24..47.
  - `sdo` per slot:
    - slot 0: right bit 0 of the previous sample (0 in the first frame after IDLE).
    - slots 1..24: left bits 23..0.
    - slots 25..47: right bits 23..1.
  - This gives the standard one-sck delay between a `ws` edge and the word MSB.
- **Sample load:** at entry to slot 1, the holding register is moved into the 48-bit shift register and the holding register is emptied.
  - If the holding register is empty, zeros are loaded and `underflow_out` pulses.
  - A write in that same clk is not bypassed: it lands in the holding register, and the zero-load and underflow still happen.
- **Drain:** the right LSB of the last sample is sent in slot 0 after stop, then all outputs return to 0.

## Timing
- Each slot = 2*SCK_HALF clk. `sck` is low for the first SCK_HALF clk of the slot and high for the rest.
- `ws` and `sdo` change only at slot boundaries, i.e. on the same clk edge where `sck` falls.
- They are therefore stable through the `sck` rising edge, which is the receiver's sampling point.
- Entry to RUN: the clk after `play_in` is sampled 1 in IDLE. Slot 0 begins with `sck`=0, `ws`=0, `sdo`=0.
- First `sck` rise: SCK_HALF clk after RUN entry.
- Sample load: 2*SCK_HALF clk after RUN entry, then every 96*SCK_HALF clk (one frame; 384 clk at the default).
- `underflow_out` is asserted in the clk where slot 1 begins.
- Back to IDLE: the clk where slot 1 would have begun. From then on, outputs are 0 and slot and sck counters are 0.
- `rst` mid-frame: everything returns to reset values on the next clk with no drain. The holding register contents are discarded.

## Structure
- Shared package `audioport_pkg` holds:
  - `I2S_WORD_W`=24 and `I2S_FRAME_SLOTS`=48.
  - Typedef `i2s_state_t` {IDLE, RUN, STOP}.
  - Typedef `audio_sample_t` (logic [1:0][23:0]).
- Single module; no sub-module is needed. Internal elements:
  - sck phase counter.
  - 6-bit slot counter.
  - 48-bit shift register plus a saved right LSB.
  - Holding register with a full flag.
  - State register.

## Test plan
- **Reset/IDLE:** hold `rst`=1 for 2 clk, then `play_in`=0 for 1000 clk -> `sck`/`ws`/`sdo`/`underflow_out` stay 0 and `audio_in_ready`=1.
- **Single frame:** write 48'hA5A5A5_3C3C3C in IDLE, then `play_in`=1 -> `audio_in_ready` falls right after the write and rises 8 clk after RUN entry. The `i2s_if` monitor returns (A5A5A5, 3C3C3C) with `tx_ok`=1.
- **Streaming:** write random samples each time `audio_in_ready`=1 over 20 frames -> every monitored pair matches in order. `ws` period = 384 clk, `sck` period = 8 clk, and `underflow_out` is never asserted.
- **Underflow:** run with no writes -> `underflow_out` pulses once per 384 clk and the monitor returns (000000, 000000).
- **Stop mid-frame:** drop `play_in` at slot 10 of a frame carrying 48'hFFFFFF_000001 -> the frame completes, including slot 0 of the next frame with `sdo`=1. After that, all outputs are 0. Reasserting `play_in` during the drain continues with no gap.
- **Reset mid-frame:** assert `rst` at slot 30 with the holding register full -> the next clk shows reset values and `audio_in_ready`=1.
